// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 32-bit ALU between two requesters (port 0 and port 1).
//   A request (op, a, b) is accepted in IDLE, executed for one cycle in EXEC
//   from latched operands, and the registered result, zero and illegal-op
//   flags are offered to the issuing port in RESP until that port takes them.
//
// Handshake semantics (both request and response channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The source holds valid and its payload stable until that edge. Request
//   ready is only ever asserted in IDLE and only to the arbitration winner.
//   Response valid is only asserted in RESP and only to the owning port; the
//   other port's resp_ready is ignored.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN  defined     -> fixed priority, port 0 wins ties,
//                                         no round-robin history register.
//                          not defined -> round-robin on ties (default).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pX_req_valid/ready       request handshake per port
//   pX_op, pX_a, pX_b        request payload per port
//   pX_resp_valid/ready      response handshake per port
//   resp_result/zero/err     shared response payload
//   busy                     high whenever the FSM is not in IDLE

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [3:0]  p0_op,
  input  logic [31:0] p0_a,
  input  logic [31:0] p0_b,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [3:0]  p1_op,
  input  logic [31:0] p1_a,
  input  logic [31:0] p1_b,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_LUI = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;

  state_t      state_q, state_d;
  logic        owner_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] res_q;
  logic        zero_q, err_q;

  logic        gnt;
  logic        tie_gnt;
  logic        accept;
  logic        resp_hs;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        op_illegal;

  // ---------------------------------------------------------------------------
  // Tie-break source
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tie_gnt = 1'b0;
`else
  logic last_q;

  // last_q resets to 1 so port 0 wins the first tie.
  assign tie_gnt = ~last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // ALU: driven only from latched operands. Shift amount is a_q[4:0] applied
  // to b_q; SLT compares unsigned.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result = 32'd0;
    case (op_q)
      OP_ADD:  alu_result = a_q + b_q;
      OP_SUB:  alu_result = a_q - b_q;
      OP_SLT:  alu_result = {31'd0, (a_q < b_q)};
      OP_AND:  alu_result = a_q & b_q;
      OP_LUI:  alu_result = {b_q[15:0], 16'd0};
      OP_NOR:  alu_result = ~(a_q | b_q);
      OP_OR:   alu_result = a_q | b_q;
      OP_XOR:  alu_result = a_q ^ b_q;
      OP_SLL:  alu_result = b_q << a_q[4:0];
      OP_SRA:  alu_result = $unsigned($signed(b_q) >>> a_q[4:0]);
      OP_SRL:  alu_result = b_q >> a_q[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  assign alu_zero   = (alu_result == 32'd0);
  assign op_illegal = (op_q > OP_SRL);

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    gnt           = 1'b0;
    accept        = 1'b0;
    resp_hs       = 1'b0;
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req_valid || p1_req_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
          if (p0_req_valid && p1_req_valid) begin
            gnt = tie_gnt;
          end else begin
            gnt = p1_req_valid;
          end
          p0_req_ready = ~gnt;
          p1_req_ready = gnt;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        p0_resp_valid = ~owner_q;
        p1_resp_valid = owner_q;
        resp_hs       = owner_q ? p1_resp_ready : p0_resp_ready;
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, request latch and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt;
        op_q    <= gnt ? p1_op : p0_op;
        a_q     <= gnt ? p1_a  : p0_a;
        b_q     <= gnt ? p1_b  : p0_b;
      end
      // Response registers load only at the end of EXEC, so they stay stable
      // for the whole of RESP regardless of backpressure.
      if (state_q == EXEC) begin
        if (op_illegal) begin
          res_q  <= 32'd0;
          zero_q <= 1'b1;
          err_q  <= 1'b1;
        end else begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          err_q  <= 1'b0;
        end
      end
    end
  end

  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit `ALU` instance between two requesters (port 0 and port 1) using a valid/ready request handshake and a valid/ready response handshake. Each request carries `op`, `a` and `b`. The block returns the latched result and zero flag to the requester that issued the operation. It sits between the CPU datapath and an auxiliary requester, such as an address/debug unit, that needs ALU cycles without a second ALU.

## Interface
- No parameters; data width fixed at 32, op width fixed at 4.
- `clk` input 1: sole clock; rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `p0_req_valid`, `p1_req_valid` input 1 each: request present.
- `p0_req_ready`, `p1_req_ready` output 1 each: request accepted this cycle.
- `p0_op`, `p1_op` input 4 each: ALU op code. ADD=0, SUB=1, SLT=2, AND=3, LUI=4, NOR=5, OR=6, XOR=7, SLL=8, SRA=9, SRL=10.
- `p0_a`, `p0_b`, `p1_a`, `p1_b` input 32 each: operands.
- `p0_resp_valid`, `p1_resp_valid` output 1 each: response present.
- `p0_resp_ready`, `p1_resp_ready` input 1 each: requester takes the response.
- `resp_result` output 32: shared response data.
- `resp_zero` output 1: shared zero flag.
- `resp_err` output 1: shared illegal-op flag.
- `busy` output 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If no valid request: stay in IDLE.
  - Otherwise select a winner `gnt` and assert `pX_req_ready` for the winner only. `pX_req_ready` is combinational from the valids and the state.
  - On that edge: latch op/a/b into `op_q/a_q/b_q`, record `owner <= gnt`, go to EXEC.
- **EXEC**
  - The ALU is driven only from `op_q/a_q/b_q`.
  - On the edge: `resp_result <= ALU.result`, `resp_zero <= ALU.zero`, `resp_err <= 0`, go to RESP.
  - If `op_q` is 11–15: `resp_result <= 0`, `resp_zero <= 1`, `resp_err <= 1`. The ALU output is ignored in this case.
- **RESP**
  - `p<owner>_resp_valid` = 1; the other port's resp_valid stays 0.
  - `resp_result`, `resp_zero` and `resp_err` hold stable.
  - When `p<owner>_resp_ready` = 1, go to IDLE. The other port's resp_ready is ignored.
- **Arbitration** (round-robin)
  - Register `last` records the most recent winner. Reset value 1, so port 0 wins the first tie.
  - Only one valid: that port wins.
  - Both valid: port `~last` wins.
  - `last <= gnt` on acceptance only.
- **Requester rules**
  - A requester holds valid, op and operands stable until ready.
  - A losing requester keeps valid asserted and is served on the next IDLE visit.
  - A requester may re-request in the cycle after its response handshake.
- **Operand/result rules**: all arithmetic is 32-bit, wrap-around. Shifts use `a_q[4:0]` as the amount applied to `b_q`. SLT is unsigned.

## Timing
- Request accepted at edge N. EXEC occupies cycle N+1. `resp_valid` is high from cycle N+2.
- Response handshake at edge M returns the block to IDLE at cycle M+1. A new request can be accepted at edge M+1.
- Peak throughput: one op per 3 cycles.
- Reset values: state=IDLE, `last`=1, `owner`=0, `op_q/a_q/b_q`=0, `resp_result`=0, `resp_zero`=0, `resp_err`=0. All ready/valid outputs are 0 and `busy`=0.
- Reset asserted in EXEC or RESP: the pending operation is dropped with no response, and the block returns to IDLE with reset values.
- Simultaneous valids during EXEC/RESP: no ready is issued. Arbitration happens only in IDLE.
- Response backpressure of unbounded length is legal. Outputs do not change while resp_ready is low.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; port 0 always wins a tie.
  - The `last` register is not built.
  - Port 1 may starve; that is accepted by design.
- Not defined (default): round-robin exactly as in Operation.

## Test plan
- **Single op**: p0 ADD a=5, b=7 accepted at edge N, resp_ready held high → p0_resp_valid at N+2 with result=12, zero=0, err=0. p1_resp_valid stays 0 throughout.
- **Tie after reset**: both valid at the same cycle (p0 SUB 9−9, p1 OR 0xF0|0x0F) → p0 served first with result=0, zero=1. p1 is accepted in the cycle after p0's response handshake and returns 0xFF. A second tie is then granted to p0.
- **Backpressure**: p1 SRA a=4, b=0x80000000, resp_ready low for 5 cycles → result holds at 0xF8000000. busy=1 and no ready is issued to p0 (valid high) until the handshake.
- **Illegal op**: p0 op=4'b1100 → result=0, zero=1, err=1. A following legal LUI b=0x1234 returns 0x12340000 with err=0.
- **Mid-op reset**: rst pulsed asynchronously during EXEC → all outputs 0 immediately, no response for the dropped op. The next p1 request completes normally.
- **Fixed priority** (build with `ALU_ARB_FIXED_PRIO_EN`): both ports valid continuously → every grant goes to port 0.
